// File: rtl/btb_updater.sv
// btb_updater: clears, then read-modify-writes, an 8-set x 2-way BTB storage file.
// Define BTB_UPDATER_STATS_EN to add the stat_hits/stat_misses/stat_allocs counters.
module btb_updater (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [31:0]  ex_pc,
  input  logic [31:0]  ex_target,
  input  logic         ex_taken,
  input  logic         ex_is_jump,
  input  logic         flush,
  output logic [2:0]   update_index,
  input  logic [127:0] update_set,
  output logic [2:0]   write_index,
  output logic [127:0] write_set,
  output logic         write_en,
  output logic         busy
`ifdef BTB_UPDATER_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses,
  output logic [31:0]  stat_allocs
`endif
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        r_valid_q, r_valid_d;
  logic [2:0]  r_index_q, r_index_d;
  logic [26:0] r_tag_q, r_tag_d;
  logic [31:0] r_target_q, r_target_d;
  logic        r_taken_q, r_taken_d;
  logic        r_jump_q, r_jump_d;

  logic        accept;
  logic        u2_active;
  logic        do_write;
  logic [61:0] way0, way1;
  logic        lru_rd;
  logic        hit0, hit1, hit, sel_way;
  logic [61:0] sel_old, sel_new;
  logic [1:0]  ctr_old, ctr_new;
  logic [127:0] upd_set;
  logic        unused_bits;

  assign way0        = update_set[61:0];
  assign way1        = update_set[123:62];
  assign lru_rd      = update_set[124];
  assign unused_bits = ^{ex_pc[1:0], update_set[127:125]};

  assign accept    = ex_valid && ex_ready;
  assign u2_active = r_valid_q && (state_q == ST_IDLE) && !flush;
  assign do_write  = u2_active && (hit || r_taken_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= 3'd0;
      r_valid_q  <= 1'b0;
      r_index_q  <= 3'd0;
      r_tag_q    <= 27'd0;
      r_target_q <= 32'd0;
      r_taken_q  <= 1'b0;
      r_jump_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      r_valid_q  <= r_valid_d;
      r_index_q  <= r_index_d;
      r_tag_q    <= r_tag_d;
      r_target_q <= r_target_d;
      r_taken_q  <= r_taken_d;
      r_jump_q   <= r_jump_d;
    end
  end

  // Next-state logic, including the U1 request register
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    r_valid_d  = accept;
    r_index_d  = r_index_q;
    r_tag_d    = r_tag_q;
    r_target_d = r_target_q;
    r_taken_d  = r_taken_q;
    r_jump_d   = r_jump_q;
    if (accept) begin
      r_index_d  = ex_pc[4:2];
      r_tag_d    = ex_pc[31:5];
      r_target_d = ex_target;
      r_taken_d  = ex_taken;
      r_jump_d   = ex_is_jump;
    end
    case (state_q)
      ST_CLEAR: begin
        if (flush) begin
          ptr_d = 3'd0;
        end else if (ptr_q == 3'd7) begin
          state_d = ST_IDLE;
          ptr_d   = 3'd0;
        end else begin
          ptr_d = ptr_q + 3'd1;
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_CLEAR;
          ptr_d   = 3'd0;
        end
      end
    endcase
  end

  // U2 datapath: hit detection, victim choice and the merged set image
  always_comb begin
    hit0 = way0[61] && (way0[60:34] == r_tag_q);
    hit1 = way1[61] && (way1[60:34] == r_tag_q);
    hit  = hit0 || hit1;
    if (hit)            sel_way = !hit0;
    else if (!way0[61]) sel_way = 1'b0;
    else if (!way1[61]) sel_way = 1'b1;
    else                sel_way = lru_rd;
    sel_old = sel_way ? way1 : way0;
    ctr_old = sel_old[1:0];
    ctr_new = ctr_old;
    sel_new = sel_old;
    if (hit) begin
      if (r_taken_q) begin
        ctr_new = (r_jump_q || ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'd1;
        sel_new = {sel_old[61:34], r_target_q, ctr_new};
      end else begin
        ctr_new = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'd1;
        sel_new = {sel_old[61:2], ctr_new};
      end
    end else begin
      sel_new = {1'b1, r_tag_q, r_target_q, (r_jump_q ? 2'b11 : 2'b10)};
    end
    upd_set = {3'b000, !sel_way,
               (sel_way ? sel_new : way1),
               (sel_way ? way0 : sel_new)};
  end

  // Outputs
  always_comb begin
    ex_ready     = (state_q == ST_IDLE) && !flush;
    busy         = (state_q == ST_CLEAR);
    update_index = r_index_q;
    write_en     = 1'b0;
    write_index  = r_index_q;
    write_set    = '0;
    if (state_q == ST_CLEAR) begin
      write_en    = rst_n;
      write_index = ptr_q;
    end else if (do_write) begin
      write_en  = 1'b1;
      write_set = upd_set;
    end
  end

`ifdef BTB_UPDATER_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;
  logic [31:0] stat_allocs_q, stat_allocs_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    stat_allocs_d = stat_allocs_q;
    if (u2_active) begin
      if (hit) begin
        stat_hits_d = stat_hits_q + 32'd1;
      end else begin
        stat_misses_d = stat_misses_q + 32'd1;
        if (r_taken_q) stat_allocs_d = stat_allocs_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits_q   <= 32'd0;
      stat_misses_q <= 32'd0;
      stat_allocs_q <= 32'd0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
      stat_allocs_q <= stat_allocs_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
  assign stat_allocs = stat_allocs_q;
`endif

endmodule

// File: tb/tb_btb_updater.sv
// Directed bench for btb_updater with a behavioural model of the 8-set storage file.
module tb_btb_updater;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_ready;
  logic [31:0]  ex_pc = '0;
  logic [31:0]  ex_target = '0;
  logic         ex_taken = 1'b0;
  logic         ex_is_jump = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   update_index;
  logic [127:0] update_set;
  logic [2:0]   write_index;
  logic [127:0] write_set;
  logic         write_en;
  logic         busy;
`ifdef BTB_UPDATER_STATS_EN
  logic [31:0]  stat_hits, stat_misses, stat_allocs;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] mem [8];
  logic         poke_en = 1'b0;
  logic [2:0]   poke_idx = '0;
  logic [127:0] poke_val = '0;

  localparam logic [61:0] W_A = {1'b1, 27'h80,  32'h0000_2000, 2'b10};
  localparam logic [61:0] W_B = {1'b1, 27'h100, 32'h0000_3000, 2'b10};
  localparam logic [61:0] W_C = {1'b1, 27'h180, 32'h0000_4000, 2'b11};

  always #5 clk = ~clk;

  assign update_set = mem[update_index];
  always @(posedge clk) begin
    if (write_en) mem[write_index] <= write_set;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  btb_updater dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken), .ex_is_jump(ex_is_jump),
    .flush(flush), .update_index(update_index), .update_set(update_set),
    .write_index(write_index), .write_set(write_set), .write_en(write_en), .busy(busy)
`ifdef BTB_UPDATER_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_allocs(stat_allocs)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [2:0] idx, input logic [127:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    step();
    poke_en = 1'b0;
  endtask

  // Presents one request for a single cycle; returns at the negedge of its U2 cycle.
  task automatic drive_req(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic jump);
    $display("req pc=%h target=%h taken=%0b jump=%0b", pc, tgt, taken, jump);
    ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_taken = taken; ex_is_jump = jump;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (write_en !== 1'b1 || write_index !== 3'(i) || write_set !== 128'd0) begin
        errors++;
        $display("FAIL %s_clear[%0d]: got we=%0b idx=%0d set=%h expected we=1 idx=%0d set=0",
                 tag, i, write_en, write_index, write_set, i);
      end
      checks++;
      if (busy !== 1'b1 || ex_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy[%0d]: got busy=%0b ready=%0b expected busy=1 ready=0",
                 tag, i, busy, ex_ready);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || ex_ready !== 1'b1 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%0b ready=%0b we=%0b expected 0 1 0",
               tag, busy, ex_ready, write_en);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) poke(3'(i), '1);
    checks++;
    if (write_en !== 1'b0 || busy !== 1'b1 || ex_ready !== 1'b0 || update_index !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got we=%0b busy=%0b ready=%0b uidx=%0d expected 0 1 0 0",
               write_en, busy, ex_ready, update_index);
    end
    rst_n = 1'b1;
    #1;
    run_clear("reset");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== 128'd0) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got %h expected 0", i, mem[i]);
      end
    end
  endtask

  task automatic test_alloc();
    drive_req(32'h0000_1004, 32'h0000_2000, 1'b1, 1'b0);
    checks++;
    if (write_en !== 1'b1 || write_index !== 3'd1 ||
        write_set !== {3'b000, 1'b1, 62'd0, W_A}) begin
      errors++;
      $display("FAIL alloc_write: got we=%0b idx=%0d set=%h expected we=1 idx=1 set=%h",
               write_en, write_index, write_set, {3'b000, 1'b1, 62'd0, W_A});
    end
    step();
    checks++;
    if (mem[1] !== {3'b000, 1'b1, 62'd0, W_A}) begin
      errors++;
      $display("FAIL alloc_mem: got %h expected %h", mem[1], {3'b000, 1'b1, 62'd0, W_A});
    end
  endtask

  task automatic test_counter();
    logic [31:0] tgts [3];
    logic [127:0] exp;
    tgts[0] = 32'h0000_2000; tgts[1] = 32'h0000_2000; tgts[2] = 32'h0000_2400;
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h0000_1004, tgts[i], 1'b1, 1'b0);
      exp = {3'b000, 1'b1, 62'd0, 1'b1, 27'h80, tgts[i], 2'b11};
      checks++;
      if (write_en !== 1'b1 || write_set !== exp) begin
        errors++;
        $display("FAIL taken_hit[%0d]: got we=%0b set=%h expected we=1 set=%h",
                 i, write_en, write_set, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ctr [4];
    logic [127:0] exp;
    exp_ctr[0] = 2'b10; exp_ctr[1] = 2'b01; exp_ctr[2] = 2'b00; exp_ctr[3] = 2'b00;
    $display("req pc=00001004 target=00009999 taken=0 x4 back-to-back");
    ex_valid = 1'b1; ex_pc = 32'h0000_1004; ex_target = 32'h0000_9999;
    ex_taken = 1'b0; ex_is_jump = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {3'b000, 1'b1, 62'd0, 1'b1, 27'h80, 32'h0000_2400, exp_ctr[i]};
      checks++;
      if (write_en !== 1'b1 || write_set !== exp) begin
        errors++;
        $display("FAIL nt_hit[%0d]: got we=%0b set=%h expected we=1 set=%h",
                 i, write_en, write_set, exp);
      end
      if (i == 3) ex_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (mem[1] !== {3'b000, 1'b1, 62'd0, 1'b1, 27'h80, 32'h0000_2400, 2'b00}) begin
      errors++;
      $display("FAIL nt_hit_mem: got %h expected valid entry counter 00", mem[1]);
    end
  endtask

  task automatic test_nt_miss();
    drive_req(32'h0000_4008, 32'h0000_0100, 1'b0, 1'b0);
    checks++;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL nt_miss_we: got %0b expected 0", write_en);
    end
    step();
    checks++;
    if (mem[2] !== 128'd0) begin
      errors++;
      $display("FAIL nt_miss_mem: got %h expected 0", mem[2]);
    end
  endtask

  task automatic test_flush_u2();
    drive_req(32'h0000_1004, 32'h0000_5000, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (write_en !== 1'b0 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_u2_drop: got we=%0b ready=%0b expected 0 0", write_en, ex_ready);
    end
    step();
    flush = 1'b0;
    run_clear("flush");
    checks++;
    if (mem[1] !== 128'd0) begin
      errors++;
      $display("FAIL flush_mem: got %h expected 0", mem[1]);
    end
`ifdef BTB_UPDATER_STATS_EN
    checks++;
    if (stat_hits !== 32'd7 || stat_misses !== 32'd2 || stat_allocs !== 32'd1) begin
      errors++;
      $display("FAIL flush_stats: got h=%0d m=%0d a=%0d expected 7 2 1",
               stat_hits, stat_misses, stat_allocs);
    end
`endif
  endtask

  task automatic test_flush_in_clear();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step(); step();
    checks++;
    if (write_index !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_mid: got idx=%0d busy=%0b expected 3 1", write_index, busy);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_clear("reclear");
  endtask

  task automatic test_evict();
    logic [127:0] exp;
    drive_req(32'h0000_1004, 32'h0000_2000, 1'b1, 1'b0);
    exp = {3'b000, 1'b1, 62'd0, W_A};
    checks++;
    if (write_en !== 1'b1 || write_set !== exp) begin
      errors++;
      $display("FAIL evict_fill0: got we=%0b set=%h expected %h", write_en, write_set, exp);
    end
    step();
    drive_req(32'h0000_2004, 32'h0000_3000, 1'b1, 1'b0);
    exp = {3'b000, 1'b0, W_B, W_A};
    checks++;
    if (write_en !== 1'b1 || write_index !== 3'd1 || write_set !== exp) begin
      errors++;
      $display("FAIL evict_fill1: got we=%0b idx=%0d set=%h expected %h",
               write_en, write_index, write_set, exp);
    end
    step();
    drive_req(32'h0000_3004, 32'h0000_4000, 1'b1, 1'b1);
    exp = {3'b000, 1'b1, W_B, W_C};
    checks++;
    if (write_en !== 1'b1 || write_set !== exp) begin
      errors++;
      $display("FAIL evict_lru: got we=%0b set=%h expected %h", write_en, write_set, exp);
    end
    step();
    poke(3'd1, mem[1] | {3'b111, 125'd0});
    drive_req(32'h0000_2004, 32'h0000_3300, 1'b1, 1'b0);
    exp = {3'b000, 1'b0, 1'b1, 27'h100, 32'h0000_3300, 2'b11, W_C};
    checks++;
    if (write_en !== 1'b1 || write_set !== exp) begin
      errors++;
      $display("FAIL way1_hit: got we=%0b set=%h expected %h", write_en, write_set, exp);
    end
    step();
`ifdef BTB_UPDATER_STATS_EN
    checks++;
    if (stat_hits !== 32'd8 || stat_misses !== 32'd5 || stat_allocs !== 32'd4) begin
      errors++;
      $display("FAIL final_stats: got h=%0d m=%0d a=%0d expected 8 5 4",
               stat_hits, stat_misses, stat_allocs);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive_req(32'h0000_1004, 32'h0000_7000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (write_en !== 1'b0 || busy !== 1'b1 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got we=%0b busy=%0b ready=%0b expected 0 1 0",
               write_en, busy, ex_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    run_clear("rstmid");
    checks++;
    if (mem[1] !== 128'd0) begin
      errors++;
      $display("FAIL rstmid_mem: got %h expected 0", mem[1]);
    end
`ifdef BTB_UPDATER_STATS_EN
    checks++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_allocs !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_stats: got h=%0d m=%0d a=%0d expected 0 0 0",
               stat_hits, stat_misses, stat_allocs);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alloc();
    test_counter();
    test_back_to_back();
    test_nt_miss();
    test_flush_u2();
    test_flush_in_clear();
    test_evict();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
